incr_stream: RTL

- Parametrised successor to the 4-bit registered incrementer.
- Adds configurable width, a per-transaction step, wrap/saturate mode, an overflow flag, and valid/ready handshakes on both sides.
- A 2-entry output buffer sustains one result per cycle under backpressure, with ready_o driven from a register.
- Sits between a producer and a consumer stage in the datapath.

---
 rtl/incr_stream.sv | 106 ++++++++++
 1 files changed

// File: rtl/incr_stream.sv
// Streaming incrementer with wrap/saturate modes and a 2-entry result buffer.
// Optional overflow counter ports are enabled by defining INCR_STREAM_OVF_CNT_EN.
module incr_stream #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [WIDTH-1:0]  data_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic              sat_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [WIDTH-1:0]  data_o,
`ifdef INCR_STREAM_OVF_CNT_EN
  output logic              ovf_o,
  output logic [15:0]       ovf_cnt_o,
  input  logic              ovf_cnt_clr_i
`else
  output logic              ovf_o
`endif
);

  // Handshake: push = valid_i && ready_o, pop = valid_o && ready_i; inputs are
  // only sampled on a push, and the head entry holds while valid_o && !ready_i.
  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   sum;
  logic             carry;
  logic [WIDTH-1:0] result;

  logic [WIDTH-1:0] res_q [2];
  logic [1:0]       ovf_q;
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             ready_q;
  logic             valid_q;
  logic             push;
  logic             pop;

  assign step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step_i};
  assign sum      = {1'b0, data_i} + step_ext;
  assign carry    = sum[WIDTH];
  assign result   = (sat_i && carry) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];

  assign push    = valid_i && ready_q;
  assign pop     = valid_q && ready_i;
  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign data_o  = res_q[rd_ptr_q];
  assign ovf_o   = ovf_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // ready/valid are registered copies of the next count, so ready_i never
  // reaches ready_o combinationally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_q[0] <= '0;
      res_q[1] <= '0;
      ovf_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      if (push) begin
        res_q[wr_ptr_q] <= result;
        ovf_q[wr_ptr_q] <= carry;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
      ready_q <= (count_d != 2'd2);
      valid_q <= (count_d != 2'd0);
    end
  end

`ifdef INCR_STREAM_OVF_CNT_EN
  logic [15:0] ovf_cnt_q;

  assign ovf_cnt_o = ovf_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || ovf_cnt_clr_i) begin
      ovf_cnt_q <= 16'd0;
    end else if (pop && ovf_q[rd_ptr_q] && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end
  end
`endif

endmodule
